// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin AXIS arbiter: one owner per packet, grant held to tlast,
// with an optional beat-count watchdog that truncates and flushes runaway packets.

module axis_pkt_rr_lane #(
    parameter int DW = 64,
    parameter int KW = 8
) (
    input  logic          sel_i,
    input  logic          pass_i,
    input  logic          flush_i,
    input  logic          m_tready_i,
    input  logic          tvalid_i,
    input  logic [DW-1:0] tdata_i,
    input  logic [KW-1:0] tkeep_i,
    input  logic          tlast_i,
    output logic          tready_o,
    output logic          tvalid_o,
    output logic [DW-1:0] tdata_o,
    output logic [KW-1:0] tkeep_o,
    output logic          tlast_o
);
    // Non-selected lanes contribute zero so the top can OR-reduce instead of indexing.
    assign tvalid_o = sel_i & tvalid_i;
    assign tlast_o  = sel_i & tlast_i;
    assign tdata_o  = sel_i ? tdata_i : '0;
    assign tkeep_o  = sel_i ? tkeep_i : '0;
    assign tready_o = sel_i & ((pass_i & m_tready_i) | flush_i);
endmodule

module axis_pkt_rr_arbiter #(
    parameter int N_INPUTS   = 4,
    parameter int DATA_BYTES = 8,
    parameter int MAX_BEATS  = 256
) (
    input  logic                             clk,
    input  logic                             areset,
    input  logic [N_INPUTS-1:0]              s_tvalid,
    output logic [N_INPUTS-1:0]              s_tready,
    input  logic [N_INPUTS*DATA_BYTES*8-1:0] s_tdata,
    input  logic [N_INPUTS*DATA_BYTES-1:0]   s_tkeep,
    input  logic [N_INPUTS-1:0]              s_tlast,
    output logic                             m_tvalid,
    input  logic                             m_tready,
    output logic [DATA_BYTES*8-1:0]          m_tdata,
    output logic [DATA_BYTES-1:0]            m_tkeep,
    output logic                             m_tlast,
    output logic                             grant_valid,
    output logic [$clog2(N_INPUTS)-1:0]      grant_idx,
    output logic                             truncated
);
    localparam int IW = $clog2(N_INPUTS);
    localparam int DW = DATA_BYTES * 8;
    localparam int KW = DATA_BYTES;
    localparam int CW = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

    typedef enum logic [1:0] {IDLE, PASS, FLUSH} state_e;

    state_e          state_q;
    logic [IW-1:0]   last_grant_q;
    logic [IW-1:0]   grant_idx_q;
    logic [CW-1:0]   beat_cnt_q;
    logic            truncated_q;

    logic [N_INPUTS-1:0][DW-1:0] tdata_arr;
    logic [N_INPUTS-1:0][KW-1:0] tkeep_arr;
    logic [N_INPUTS-1:0][DW-1:0] lane_data;
    logic [N_INPUTS-1:0][KW-1:0] lane_keep;
    logic [N_INPUTS-1:0]         lane_valid;
    logic [N_INPUTS-1:0]         lane_last;
    logic [N_INPUTS-1:0]         gnt_oh;

    logic          in_pass, in_flush;
    logic          sel_valid, sel_last;
    logic [DW-1:0] sel_data;
    logic [KW-1:0] sel_keep;
    logic          wd_hit;
    logic          xfer, flush_acc;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

    assign tdata_arr = s_tdata;
    assign tkeep_arr = s_tkeep;
    assign in_pass   = (state_q == PASS);
    assign in_flush  = (state_q == FLUSH);

    genvar gi;
    generate
        for (gi = 0; gi < N_INPUTS; gi++) begin : g_lane
            assign gnt_oh[gi] = (grant_idx_q == IW'(gi));
            axis_pkt_rr_lane #(.DW(DW), .KW(KW)) u_lane (
                .sel_i      (gnt_oh[gi]),
                .pass_i     (in_pass),
                .flush_i    (in_flush),
                .m_tready_i (m_tready),
                .tvalid_i   (s_tvalid[gi]),
                .tdata_i    (tdata_arr[gi]),
                .tkeep_i    (tkeep_arr[gi]),
                .tlast_i    (s_tlast[gi]),
                .tready_o   (s_tready[gi]),
                .tvalid_o   (lane_valid[gi]),
                .tdata_o    (lane_data[gi]),
                .tkeep_o    (lane_keep[gi]),
                .tlast_o    (lane_last[gi])
            );
        end
    endgenerate

    always_comb begin
        sel_data  = '0;
        sel_keep  = '0;
        sel_valid = |lane_valid;
        sel_last  = |lane_last;
        for (int i = 0; i < N_INPUTS; i++) begin
            sel_data = sel_data | lane_data[i];
            sel_keep = sel_keep | lane_keep[i];
        end
    end

    // Walk offsets from farthest to nearest so the source right after last_grant wins.
    always_comb begin
        int unsigned c;
        pick_valid = 1'b0;
        pick_idx   = '0;
        c          = 0;
        for (int k = N_INPUTS; k >= 1; k--) begin
            c = (int'(last_grant_q) + k) % N_INPUTS;
            if (s_tvalid[c]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(c);
            end
        end
    end

    generate
        if (MAX_BEATS > 0) begin : g_wd
            assign wd_hit = (beat_cnt_q == CW'(MAX_BEATS - 1)) & ~sel_last;
        end else begin : g_no_wd
            assign wd_hit = 1'b0;
        end
    endgenerate

    assign xfer      = in_pass & sel_valid & m_tready;
    assign flush_acc = in_flush & sel_valid;

    assign m_tvalid    = in_pass & sel_valid;
    assign m_tdata     = sel_data;
    assign m_tkeep     = sel_keep;
    assign m_tlast     = in_pass & (sel_last | wd_hit);
    assign grant_valid = in_pass | in_flush;
    assign grant_idx   = grant_idx_q;
    assign truncated   = truncated_q;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q      <= IDLE;
            last_grant_q <= IW'(N_INPUTS - 1);
            grant_idx_q  <= '0;
            beat_cnt_q   <= '0;
            truncated_q  <= 1'b0;
        end else begin
            truncated_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (pick_valid) begin
                        grant_idx_q <= pick_idx;
                        beat_cnt_q  <= '0;
                        state_q     <= PASS;
                    end
                end
                PASS: begin
                    if (xfer) begin
                        // Saturates at MAX_BEATS: the truncating beat leaves PASS.
                        if (MAX_BEATS > 0) beat_cnt_q <= beat_cnt_q + 1'b1;
                        if (sel_last) begin
                            last_grant_q <= grant_idx_q;
                            state_q      <= IDLE;
                        end else if (wd_hit) begin
                            truncated_q <= 1'b1;
                            state_q     <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    if (flush_acc && sel_last) begin
                        last_grant_q <= grant_idx_q;
                        state_q      <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_axis_pkt_rr_arbiter.sv
// Directed bench for axis_pkt_rr_arbiter: 4 sources, 16-bit data, watchdog at 4 beats.

module tb_axis_pkt_rr_arbiter;
    localparam int N  = 4;
    localparam int DB = 2;
    localparam int MB = 4;

    logic              clk = 1'b0;
    logic              areset;
    logic [N-1:0]      s_tvalid, s_tready, s_tlast;
    logic [N*DB*8-1:0] s_tdata;
    logic [N*DB-1:0]   s_tkeep;
    logic              m_tvalid, m_tready, m_tlast;
    logic [DB*8-1:0]   m_tdata;
    logic [DB-1:0]     m_tkeep;
    logic              grant_valid, truncated;
    logic [1:0]        grant_idx;

    axis_pkt_rr_arbiter #(.N_INPUTS(N), .DATA_BYTES(DB), .MAX_BEATS(MB)) dut (
        .clk(clk), .areset(areset),
        .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tvalid(m_tvalid), .m_tready(m_tready), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast),
        .grant_valid(grant_valid), .grant_idx(grant_idx), .truncated(truncated)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Source model: each source sends src_pkts packets of src_tot beats; data = {src, beat}.
    int src_pkts[N], src_tot[N], src_beat[N], acc[N];
    logic [N-1:0] hold;
    int log_src[$], log_beat[$], log_last[$], log_cyc[$];
    int cyc = 0, trunc_cnt = 0, trunc_cyc = -1;
    logic        c_mv, c_ml, c_gv, c_tr;
    logic [15:0] c_md;
    logic [3:0]  c_sr;
    logic [1:0]  c_gi;

    task automatic clear_model();
        for (int i = 0; i < N; i++) begin
            src_pkts[i] = 0; src_tot[i] = 0; src_beat[i] = 0; acc[i] = 0;
        end
        hold = '0;
        log_src.delete(); log_beat.delete(); log_last.delete(); log_cyc.delete();
        trunc_cnt = 0; trunc_cyc = -1;
    endtask

    task automatic drive();
        for (int i = 0; i < N; i++) begin
            s_tvalid[i]            = (src_pkts[i] > 0) && !hold[i];
            s_tdata[i*16 +: 16]    = 16'((i << 12) | src_beat[i]);
            s_tkeep[i*2 +: 2]      = 2'b11;
            s_tlast[i]             = (src_beat[i] == src_tot[i] - 1);
        end
    endtask

    // One cycle: drive at negedge, sample, then advance the sources on the posedge handshake.
    task automatic step();
        logic [N-1:0] hs;
        drive();
        #1;
        c_mv = m_tvalid; c_md = m_tdata; c_ml = m_tlast; c_sr = s_tready;
        c_gv = grant_valid; c_gi = grant_idx; c_tr = truncated;
        if (m_tvalid && m_tready) begin
            log_src.push_back(int'(m_tdata[15:12]));
            log_beat.push_back(int'(m_tdata[11:0]));
            log_last.push_back(int'(m_tlast));
            log_cyc.push_back(cyc);
        end
        if (truncated) begin
            trunc_cnt++;
            trunc_cyc = cyc;
        end
        hs = s_tvalid & s_tready;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (hs[i]) begin
                acc[i]++;
                if (src_beat[i] == src_tot[i] - 1) begin
                    src_pkts[i]--;
                    src_beat[i] = 0;
                end else begin
                    src_beat[i]++;
                end
            end
        end
        cyc++;
        @(negedge clk);
    endtask

    function automatic bit busy();
        busy = 1'b0;
        for (int i = 0; i < N; i++) if (src_pkts[i] > 0) busy = 1'b1;
    endfunction

    task automatic test_reset();
        @(negedge clk);
        drive();
        #1;
        total++; if (m_tvalid !== 1'b0) begin bad++; $display("FAIL reset_mtvalid got=%0b exp=0", m_tvalid); end
        total++; if (s_tready !== 4'b0) begin bad++; $display("FAIL reset_stready got=%b exp=0000", s_tready); end
        total++; if (grant_valid !== 1'b0) begin bad++; $display("FAIL reset_gvalid got=%0b exp=0", grant_valid); end
        total++; if (grant_idx !== 2'd0) begin bad++; $display("FAIL reset_gidx got=%0d exp=0", grant_idx); end
        total++; if (truncated !== 1'b0) begin bad++; $display("FAIL reset_trunc got=%0b exp=0", truncated); end
        @(negedge clk);
        src_pkts[1] = 1; src_tot[1] = 1;
        step(); step();
        total++; if (c_gv !== 1'b0 || c_sr !== 4'b0) begin bad++; $display("FAIL reset_held gv=%0b sr=%b exp 0/0000", c_gv, c_sr); end
        clear_model();
        areset = 1'b0;
        step();
        total++; if (c_gv !== 1'b0 || c_mv !== 1'b0) begin bad++; $display("FAIL reset_idle gv=%0b mv=%0b exp 0/0", c_gv, c_mv); end
    endtask

    task automatic test_single();
        clear_model();
        m_tready = 1'b1;
        src_pkts[2] = 1; src_tot[2] = 3;
        step();
        total++; if (c_mv !== 1'b0 || c_sr !== 4'b0) begin bad++; $display("FAIL single_arb mv=%0b sr=%b exp 0/0000", c_mv, c_sr); end
        for (int k = 0; k < 3; k++) begin
            step();
            total++;
            if (c_mv !== 1'b1 || c_gi !== 2'd2 || c_sr !== 4'b0100 ||
                c_md !== 16'(16'h2000 + k) || c_ml !== (k == 2)) begin
                bad++;
                $display("FAIL single_beat%0d mv=%0b gi=%0d sr=%b d=%h l=%0b exp 1/2/0100/%h/%0b",
                         k, c_mv, c_gi, c_sr, c_md, c_ml, 16'(16'h2000 + k), (k == 2));
            end
        end
        step();
        total++; if (c_gv !== 1'b0 || c_mv !== 1'b0 || c_gi !== 2'd2) begin bad++; $display("FAIL single_end gv=%0b mv=%0b gi=%0d exp 0/0/2", c_gv, c_mv, c_gi); end
    endtask

    task automatic test_round_robin();
        int n;
        areset = 1'b1;
        step();
        areset = 1'b0;
        clear_model();
        m_tready = 1'b1;
        for (int i = 0; i < N; i++) begin src_pkts[i] = 2; src_tot[i] = 2; end
        n = 0;
        while (busy() && n < 40) begin step(); n++; end
        step();
        total++; if (busy()) begin bad++; $display("FAIL rr_timeout got=pending exp=drained"); end
        total++; if (log_src.size() != 16) begin bad++; $display("FAIL rr_count got=%0d exp=16", log_src.size()); end
        for (int k = 0; k < 16 && k < log_src.size(); k++) begin
            total++;
            if (log_src[k] != (k / 2) % 4 || log_beat[k] != k % 2 || log_last[k] != k % 2) begin
                bad++;
                $display("FAIL rr_beat%0d src=%0d beat=%0d last=%0d exp %0d/%0d/%0d",
                         k, log_src[k], log_beat[k], log_last[k], (k / 2) % 4, k % 2, k % 2);
            end
        end
        for (int p = 0; p < 7 && 2 * p + 2 < log_cyc.size(); p++) begin
            total++;
            if (log_cyc[2*p+2] - log_cyc[2*p+1] != 2 || log_cyc[2*p+1] - log_cyc[2*p] != 1) begin
                bad++;
                $display("FAIL rr_gap%0d gap=%0d inner=%0d exp 2/1", p,
                         log_cyc[2*p+2] - log_cyc[2*p+1], log_cyc[2*p+1] - log_cyc[2*p]);
            end
        end
        total++; if (c_gi !== 2'd3) begin bad++; $display("FAIL rr_last_gidx got=%0d exp=3", c_gi); end
    endtask

    task automatic test_watchdog();
        int n;
        clear_model();
        m_tready = 1'b1;
        src_pkts[1] = 1; src_tot[1] = 10;
        src_pkts[2] = 1; src_tot[2] = 2;
        n = 0;
        while (busy() && n < 40) begin step(); n++; end
        step();
        total++; if (busy()) begin bad++; $display("FAIL wd_timeout got=pending exp=drained"); end
        total++; if (log_src.size() != 6) begin bad++; $display("FAIL wd_count got=%0d exp=6", log_src.size()); end
        if (log_src.size() == 6) begin
            for (int k = 0; k < 6; k++) begin
                int es, eb, el;
                es = (k < 4) ? 1 : 2;
                eb = (k < 4) ? k : k - 4;
                el = (k == 3 || k == 5) ? 1 : 0;
                total++;
                if (log_src[k] != es || log_beat[k] != eb || log_last[k] != el) begin
                    bad++;
                    $display("FAIL wd_beat%0d src=%0d beat=%0d last=%0d exp %0d/%0d/%0d",
                             k, log_src[k], log_beat[k], log_last[k], es, eb, el);
                end
            end
            total++; if (trunc_cyc != log_cyc[3] + 1) begin bad++; $display("FAIL wd_trunc_time got=%0d exp=%0d", trunc_cyc, log_cyc[3] + 1); end
            total++; if (log_cyc[4] != log_cyc[3] + 8) begin bad++; $display("FAIL wd_next_grant got=%0d exp=%0d", log_cyc[4], log_cyc[3] + 8); end
        end
        total++; if (trunc_cnt != 1) begin bad++; $display("FAIL wd_trunc_cnt got=%0d exp=1", trunc_cnt); end
        total++; if (acc[1] != 10 || acc[2] != 2) begin bad++; $display("FAIL wd_accepted src1=%0d src2=%0d exp 10/2", acc[1], acc[2]); end
    endtask

    task automatic test_exact_len();
        int n;
        clear_model();
        m_tready = 1'b1;
        src_pkts[0] = 1; src_tot[0] = 4;
        n = 0;
        while (busy() && n < 20) begin step(); n++; end
        step();
        total++; if (busy()) begin bad++; $display("FAIL exact_timeout got=pending exp=drained"); end
        total++; if (log_src.size() != 4) begin bad++; $display("FAIL exact_count got=%0d exp=4", log_src.size()); end
        for (int k = 0; k < 4 && k < log_src.size(); k++) begin
            total++;
            if (log_src[k] != 0 || log_beat[k] != k || log_last[k] != (k == 3 ? 1 : 0)) begin
                bad++;
                $display("FAIL exact_beat%0d src=%0d beat=%0d last=%0d exp 0/%0d/%0d",
                         k, log_src[k], log_beat[k], log_last[k], k, (k == 3 ? 1 : 0));
            end
        end
        total++; if (trunc_cnt != 0) begin bad++; $display("FAIL exact_trunc got=%0d exp=0", trunc_cnt); end
        total++; if (c_gv !== 1'b0 || acc[0] != 4) begin bad++; $display("FAIL exact_end gv=%0b acc=%0d exp 0/4", c_gv, acc[0]); end
    endtask

    task automatic test_stall_hold();
        int n, held, stalls;
        logic        prev_stall;
        logic [15:0] prev_md;
        clear_model();
        src_pkts[1] = 1; src_tot[1] = 4;
        src_pkts[3] = 1; src_tot[3] = 1;
        m_tready = 1'b0;
        n = 0; held = 0; stalls = 0; prev_stall = 1'b0; prev_md = '0;
        while (busy() && n < 60) begin
            m_tready = ~m_tready;
            hold[1] = (src_beat[1] == 2) && (held < 3);
            if (hold[1]) held++;
            step();
            n++;
            if (c_gv && c_gi == 2'd1) begin
                total++; if ((c_sr & 4'b1101) !== 4'b0) begin bad++; $display("FAIL stall_other_ready got=%b exp=x0x0 with bit1 only", c_sr); end
            end
            if (hold[1]) begin
                total++; if (c_gv !== 1'b1 || c_gi !== 2'd1) begin bad++; $display("FAIL stall_hold gv=%0b gi=%0d exp 1/1", c_gv, c_gi); end
            end
            if (prev_stall) begin
                stalls++;
                total++; if (c_md !== prev_md) begin bad++; $display("FAIL stall_data got=%h exp=%h", c_md, prev_md); end
            end
            prev_stall = c_mv && !m_tready;
            prev_md    = c_md;
        end
        hold = '0;
        m_tready = 1'b1;
        step();
        total++; if (busy() || stalls == 0 || held != 3) begin bad++; $display("FAIL stall_run pending=%0b stalls=%0d held=%0d exp 0/>0/3", busy(), stalls, held); end
        total++; if (log_src.size() != 5) begin bad++; $display("FAIL stall_count got=%0d exp=5", log_src.size()); end
        for (int k = 0; k < 5 && k < log_src.size(); k++) begin
            int es, eb, el;
            es = (k < 4) ? 1 : 3;
            eb = (k < 4) ? k : 0;
            el = (k >= 3) ? 1 : 0;
            total++;
            if (log_src[k] != es || log_beat[k] != eb || log_last[k] != el) begin
                bad++;
                $display("FAIL stall_beat%0d src=%0d beat=%0d last=%0d exp %0d/%0d/%0d",
                         k, log_src[k], log_beat[k], log_last[k], es, eb, el);
            end
        end
    endtask

    task automatic test_areset_mid();
        clear_model();
        m_tready = 1'b1;
        src_pkts[3] = 1; src_tot[3] = 5;
        step(); step(); step();
        drive();
        #1;
        total++; if (m_tvalid !== 1'b1 || grant_idx !== 2'd3) begin bad++; $display("FAIL arst_pre mv=%0b gi=%0d exp 1/3", m_tvalid, grant_idx); end
        areset = 1'b1;
        #1;
        total++; if (m_tvalid !== 1'b0 || s_tready !== 4'b0) begin bad++; $display("FAIL arst_async mv=%0b sr=%b exp 0/0000", m_tvalid, s_tready); end
        total++; if (grant_valid !== 1'b0 || grant_idx !== 2'd0) begin bad++; $display("FAIL arst_grant gv=%0b gi=%0d exp 0/0", grant_valid, grant_idx); end
        @(negedge clk);
        clear_model();
        src_pkts[0] = 1; src_tot[0] = 1;
        src_pkts[3] = 1; src_tot[3] = 1;
        areset = 1'b0;
        step();
        total++; if (c_mv !== 1'b0) begin bad++; $display("FAIL arst_arb mv=%0b exp=0", c_mv); end
        step();
        total++;
        if (c_mv !== 1'b1 || c_gi !== 2'd0 || c_md !== 16'h0000 || c_sr !== 4'b0001 || c_ml !== 1'b1) begin
            bad++;
            $display("FAIL arst_first mv=%0b gi=%0d d=%h sr=%b l=%0b exp 1/0/0000/0001/1", c_mv, c_gi, c_md, c_sr, c_ml);
        end
        step(); step(); step();
        total++;
        if (log_src.size() != 2 || log_src[log_src.size()-1] != 3) begin
            bad++;
            $display("FAIL arst_second count=%0d exp 2 with src3 last", log_src.size());
        end
    endtask

    initial begin
        areset   = 1'b1;
        m_tready = 1'b0;
        clear_model();
        drive();
        #12;
        test_reset();
        test_single();
        test_round_robin();
        test_watchdog();
        test_exact_len();
        test_stall_hold();
        test_areset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/axis_pkt_rr_arbiter.md
Name: axis_pkt_rr_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one AXIS sink, typically the write side of a shared distributed-RAM FIFO, between N_INPUTS AXIS sources.
- The grant is held from the first beat of a packet to its tlast, so packets are never interleaved.
- An optional length watchdog truncates runaway packets and discards their remainder, so one stuck source cannot monopolise the shared FIFO.

Parameters:
- N_INPUTS, 4, number of requesting AXIS sources (2..16).
- DATA_BYTES, 8, tdata width in bytes; tkeep is DATA_BYTES bits.
- MAX_BEATS, 256, maximum beats per packet before forced truncation; 0 disables the watchdog.

Ports:
- clk  in  1  single clock for all logic.
- areset  in  1  asynchronous, active-high reset.
- s_tvalid  in  N_INPUTS  per-source tvalid.
- s_tready  out  N_INPUTS  per-source tready.
- s_tdata  in  N_INPUTS*DATA_BYTES*8  per-source tdata, source i at slice i.
- s_tkeep  in  N_INPUTS*DATA_BYTES  per-source tkeep.
- s_tlast  in  N_INPUTS  per-source tlast.
- m_tvalid  out  1  output tvalid.
- m_tready  in  1  output tready.
- m_tdata  out  DATA_BYTES*8  output tdata.
- m_tkeep  out  DATA_BYTES  output tkeep.
- m_tlast  out  1  output tlast.
- grant_valid  out  1  high while a packet is owned (states PASS and FLUSH).
- grant_idx  out  $clog2(N_INPUTS)  index of the current or most recent owner.
- truncated  out  1  one-cycle pulse when the watchdog forces tlast.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE, last_grant=N_INPUTS-1 (source 0 wins first), grant_idx=0, beat_cnt=0.
  - truncated=0, all s_tready=0, m_tvalid=0.
  - Reset mid-packet abandons the packet immediately; the downstream sink sees no tlast, and that is accepted.
- IDLE:
  - s_tready=0 and m_tvalid=0.
  - If any s_tvalid is high, register grant_idx = first set index searching last_grant+1, last_grant+2, ... with wrap N_INPUTS-1 to 0; beat_cnt=0; go to PASS.
  - Arbitration costs exactly one cycle. First output beat is visible the cycle after the request is seen.
- PASS:
  - Output datapath is purely combinational from the granted slice: m_tvalid=s_tvalid[g], m_tdata/m_tkeep=slice g, s_tready[g]=m_tready, all other s_tready=0.
  - A beat transfers when m_tvalid & m_tready; beat_cnt increments on each transfer.
  - The owner deasserting tvalid mid-packet does not release the grant; the arbiter waits indefinitely.
  - Transfer with s_tlast[g]=1: last_grant=g, go to IDLE.
  - Watchdog, MAX_BEATS>0: on the transfer with beat_cnt==MAX_BEATS-1 and s_tlast[g]=0, drive m_tlast=1 on that beat, pulse truncated next cycle, go to FLUSH.
  - If s_tlast[g]=1 on that same beat, the packet ends normally: no truncation.
  - MAX_BEATS=1 forces tlast on every beat.
- FLUSH:
  - m_tvalid=0 and s_tready[g]=1; beats from source g are discarded.
  - Accepted beat with s_tlast[g]=1: last_grant=g, go to IDLE.
- Ordering and fairness:
  - Minimum packet-to-packet gap on the output is one idle cycle.
  - With all sources continuously requesting, grants rotate 0,1,2,...,N-1,0.
  - A lone requester is re-granted back-to-back.
- Widths:
  - beat_cnt is $clog2(MAX_BEATS+1) bits and never wraps; it is cleared on entry to PASS.
  - grant_idx holds its value in IDLE until the next grant.

Test Plan:
- Reset then source 2 sends a 3-beat packet -> one IDLE cycle, then 3 beats on m_* with tlast on beat 3; grant_idx=2; return to IDLE.
- All 4 sources continuously send 2-beat packets -> output order 0,1,2,3,0,1; no interleaving; one idle cycle between packets.
- MAX_BEATS=4, source 1 sends a 10-beat packet -> output has 4 beats with tlast on beat 4; truncated pulses once; source 1 sees 10 accepted beats; next grant goes to source 2 if it is requesting.
- A 4-beat packet with tlast on beat 4 and MAX_BEATS=4 -> normal end, truncated stays 0.
- m_tready toggles 1/0 and the owner drops tvalid mid-packet -> data is unchanged, the grant is held, and no other s_tready rises until tlast.
- areset asserted mid-packet from source 3 -> m_tvalid and s_tready go to 0 asynchronously; after release, the first grant goes to source 0 if it is requesting.
